// File: rtl/project_sync_phase_controller.sv
// Sync-input controller: selects and edge-detects a sync source, delays it by i_delay cycles,
// then issues the phase-load strobe while flagging syncs lost mid-delay and late syncs.
module project_sync_phase_controller (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_sync_in,
  input  logic        i_sync_ext,
  input  logic        i_src_sel,
  input  logic        i_phase_load_en,
  input  logic        i_oneshot,
  input  logic        i_arm,
  input  logic [15:0] i_delay,
  input  logic [15:0] i_phase,
  input  logic        i_phase_dir,
  input  logic [15:0] i_timeout,
  input  logic        i_clear_flags,
  output logic        o_sync_fwd,
  output logic        o_phase_en,
  output logic [15:0] o_phase,
  output logic        o_phase_direction,
  output logic        o_busy,
  output logic        o_missed,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t      state;
  logic        ext_meta;
  logic        ext_sync;
  logic        sel_prev;
  logic        armed;
  logic [15:0] cnt;
  logic [15:0] tcnt;

  logic        sel;
  logic        sync_edge;
  logic        accept;
  logic        timeout_hit;
  logic [15:0] tcnt_next;

  assign sel         = i_src_sel ? ext_sync : i_sync_in;
  assign sync_edge   = sel & ~sel_prev;
  assign accept      = i_en & sync_edge & (state != DELAY) & (~i_oneshot | armed);
  assign tcnt_next   = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
  // An accepted sync on the same edge counts as arriving in time.
  assign timeout_hit = i_en & ~accept & (i_timeout != 16'd0) & (tcnt_next == i_timeout);
  assign o_phase_en  = o_sync_fwd & i_phase_load_en;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ext_meta          <= 1'b0;
      ext_sync          <= 1'b0;
      sel_prev          <= 1'b0;
      armed             <= 1'b0;
      o_phase           <= 16'd0;
      o_phase_direction <= 1'b0;
      tcnt              <= 16'd0;
      o_missed          <= 1'b0;
      o_timeout         <= 1'b0;
    end else begin
      ext_meta <= i_sync_ext;
      ext_sync <= ext_meta;
      sel_prev <= sel;
      // A re-arm on the same edge as a one-shot acceptance leaves the block armed.
      armed    <= i_arm | (armed & ~(accept & i_oneshot));
      if (accept) begin
        o_phase           <= i_phase;
        o_phase_direction <= i_phase_dir;
      end
      if (!i_en || accept)
        tcnt <= 16'd0;
      else if (i_timeout != 16'd0)
        tcnt <= tcnt_next;
      o_missed  <= (sync_edge & (state == DELAY)) | (o_missed & ~i_clear_flags);
      o_timeout <= timeout_hit | (o_timeout & ~i_clear_flags);
    end
  end

  // Strobe FSM; an acceptance in PULSE restarts the delay so back-to-back syncs lose no gap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      o_sync_fwd <= 1'b0;
    end else if (!i_en) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      o_sync_fwd <= 1'b0;
    end else if (accept) begin
      if (i_delay == 16'd0) begin
        state      <= PULSE;
        cnt        <= 16'd0;
        o_sync_fwd <= 1'b1;
      end else begin
        state      <= DELAY;
        cnt        <= 16'd1;
        o_sync_fwd <= 1'b0;
      end
    end else begin
      case (state)
        DELAY: begin
          if (cnt == i_delay) begin
            state      <= PULSE;
            cnt        <= 16'd0;
            o_sync_fwd <= 1'b1;
          end else begin
            cnt        <= cnt + 16'd1;
            o_sync_fwd <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 16'd0;
          o_sync_fwd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_project_sync_phase_controller.sv
// Bench for project_sync_phase_controller: vector table, directed corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_project_sync_phase_controller;

  logic        i_clk;
  logic        i_reset;
  logic        i_en;
  logic        i_sync_in;
  logic        i_sync_ext;
  logic        i_src_sel;
  logic        i_phase_load_en;
  logic        i_oneshot;
  logic        i_arm;
  logic [15:0] i_delay;
  logic [15:0] i_phase;
  logic        i_phase_dir;
  logic [15:0] i_timeout;
  logic        i_clear_flags;
  logic        o_sync_fwd;
  logic        o_phase_en;
  logic [15:0] o_phase;
  logic        o_phase_direction;
  logic        o_busy;
  logic        o_missed;
  logic        o_timeout;

  int n_checks = 0;
  int n_bad    = 0;

  project_sync_phase_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_sync_in(i_sync_in),
    .i_sync_ext(i_sync_ext), .i_src_sel(i_src_sel), .i_phase_load_en(i_phase_load_en),
    .i_oneshot(i_oneshot), .i_arm(i_arm), .i_delay(i_delay), .i_phase(i_phase),
    .i_phase_dir(i_phase_dir), .i_timeout(i_timeout), .i_clear_flags(i_clear_flags),
    .o_sync_fwd(o_sync_fwd), .o_phase_en(o_phase_en), .o_phase(o_phase),
    .o_phase_direction(o_phase_direction), .o_busy(o_busy), .o_missed(o_missed),
    .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending strobe is kept as an absolute edge number.
  int          m_n;
  int          m_strobe_at;
  int          m_elapsed;
  bit          m_prev;
  bit          m_ext_hist [2];
  bit          m_armed, m_missed, m_timeout, m_dir, m_fwd, m_busy;
  logic [15:0] m_phase;

  task automatic model_reset();
    m_strobe_at   = -1000;
    m_elapsed     = 0;
    m_prev        = 1'b0;
    m_ext_hist[0] = 1'b0;
    m_ext_hist[1] = 1'b0;
    m_armed       = 1'b0;
    m_missed      = 1'b0;
    m_timeout     = 1'b0;
    m_dir         = 1'b0;
    m_fwd         = 1'b0;
    m_busy        = 1'b0;
    m_phase       = 16'd0;
  endtask

  task automatic model_step();
    bit sel, ev, in_delay, acc, tset;
    sel = i_src_sel ? m_ext_hist[1] : i_sync_in;
    ev  = sel && !m_prev;
    m_prev        = sel;
    m_ext_hist[1] = m_ext_hist[0];
    m_ext_hist[0] = i_sync_ext;
    in_delay = (m_n <= m_strobe_at) && (m_strobe_at != m_n - 1);
    acc      = i_en && ev && !in_delay && (!i_oneshot || m_armed);
    m_missed = (ev && in_delay) || (m_missed && !i_clear_flags);
    tset = 1'b0;
    if (!i_en || acc) m_elapsed = 0;
    else if (i_timeout != 16'd0) begin
      if (m_elapsed < 65535) m_elapsed++;
      tset = (m_elapsed == int'(i_timeout));
    end
    m_timeout = tset || (m_timeout && !i_clear_flags);
    if (acc) begin
      m_phase     = i_phase;
      m_dir       = i_phase_dir;
      m_strobe_at = m_n + int'(i_delay);
    end
    m_armed = i_arm || (m_armed && !(acc && i_oneshot));
    if (!i_en) m_strobe_at = -1000;
    m_fwd  = (m_strobe_at == m_n);
    m_busy = (m_strobe_at >= m_n);
    m_n++;
  endtask

  task automatic compare_model();
    check("model fwd",     o_sync_fwd,        m_fwd);
    check("model phase_en", o_phase_en,       m_fwd & i_phase_load_en);
    check("model phase",   o_phase,           m_phase);
    check("model dir",     o_phase_direction, m_dir);
    check("model busy",    o_busy,            m_busy);
    check("model missed",  o_missed,          m_missed);
    check("model timeout", o_timeout,         m_timeout);
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
    model_step();
    compare_model();
  endtask

  typedef struct {
    logic        sync;
    logic [15:0] dly;
    logic [15:0] ph;
    logic        dir;
    logic        lden;
    logic        e_fwd;
    logic        e_pen;
    logic        e_busy;
    logic [15:0] e_ph;
    logic        e_dir;
  } vec_t;

  function automatic vec_t mk(logic s, logic [15:0] d, logic [15:0] p, logic dr, logic l,
                              logic f, logic pe, logic b, logic [15:0] ep, logic ed);
    vec_t v;
    v.sync = s; v.dly = d; v.ph = p; v.dir = dr; v.lden = l;
    v.e_fwd = f; v.e_pen = pe; v.e_busy = b; v.e_ph = ep; v.e_dir = ed;
    return v;
  endfunction

  vec_t vecs [10];
  int   strobes;
  int   pens;

  initial begin
    vecs[0] = mk(1'b0, 16'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[1] = mk(1'b1, 16'd0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
    vecs[2] = mk(1'b0, 16'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1);
    vecs[3] = mk(1'b0, 16'd2, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1);
    vecs[4] = mk(1'b1, 16'd2, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    vecs[5] = mk(1'b0, 16'd2, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    vecs[6] = mk(1'b0, 16'd2, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0);
    vecs[7] = mk(1'b0, 16'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    vecs[8] = mk(1'b1, 16'd0, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b1);
    vecs[9] = mk(1'b0, 16'd0, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1);

    i_reset = 1'b1; i_en = 1'b0; i_sync_in = 1'b0; i_sync_ext = 1'b0; i_src_sel = 1'b0;
    i_phase_load_en = 1'b1; i_oneshot = 1'b0; i_arm = 1'b0; i_delay = 16'd0;
    i_phase = 16'd0; i_phase_dir = 1'b0; i_timeout = 16'd0; i_clear_flags = 1'b0;
    m_n = 0;
    model_reset();
    #3;
    check("reset fwd",     o_sync_fwd, 1'b0);
    check("reset phase",   o_phase,    16'd0);
    check("reset busy",    o_busy,     1'b0);
    check("reset missed",  o_missed,   1'b0);
    check("reset timeout", o_timeout,  1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_en    = 1'b1;

    for (int r = 0; r < 10; r++) begin
      i_sync_in = vecs[r].sync; i_delay = vecs[r].dly; i_phase = vecs[r].ph;
      i_phase_dir = vecs[r].dir; i_phase_load_en = vecs[r].lden;
      cycle();
      check($sformatf("vec%0d fwd", r),      o_sync_fwd,        vecs[r].e_fwd);
      check($sformatf("vec%0d phase_en", r), o_phase_en,        vecs[r].e_pen);
      check($sformatf("vec%0d busy", r),     o_busy,            vecs[r].e_busy);
      check($sformatf("vec%0d phase", r),    o_phase,           vecs[r].e_ph);
      check($sformatf("vec%0d dir", r),      o_phase_direction, vecs[r].e_dir);
    end

    // Second sync lands mid-delay: one strobe only, and the loss is flagged.
    i_phase_load_en = 1'b1; i_delay = 16'd5; i_sync_in = 1'b1;
    cycle();
    for (int i = 1; i <= 7; i++) begin
      i_sync_in = (i == 3);
      cycle();
      check($sformatf("delay5 fwd edge+%0d", i), o_sync_fwd, (i == 5));
    end
    check("missed set", o_missed, 1'b1);
    i_clear_flags = 1'b1;
    cycle();
    i_clear_flags = 1'b0;
    check("missed cleared", o_missed, 1'b0);

    // One-shot: a single arm yields a single strobe across three syncs.
    i_delay = 16'd0; i_oneshot = 1'b1; i_arm = 1'b1;
    cycle();
    i_arm = 1'b0; strobes = 0;
    for (int i = 0; i < 60; i++) begin
      i_sync_in = (i % 20 == 0);
      cycle();
      if (o_sync_fwd) strobes++;
    end
    check("oneshot strobes", 16'(strobes), 16'd1);
    i_sync_in = 1'b0; i_arm = 1'b1;
    cycle();
    i_arm = 1'b0; i_sync_in = 1'b1;
    cycle();
    check("rearmed strobe", o_sync_fwd, 1'b1);
    i_sync_in = 1'b0; i_oneshot = 1'b0;
    cycle();

    // Level held high is one event; load enable low suppresses only o_phase_en.
    i_delay = 16'd2; strobes = 0; i_sync_in = 1'b1;
    repeat (10) begin cycle(); if (o_sync_fwd) strobes++; end
    i_sync_in = 1'b0;
    repeat (5) begin cycle(); if (o_sync_fwd) strobes++; end
    check("held-high strobes", 16'(strobes), 16'd1);
    i_phase_load_en = 1'b0; strobes = 0; pens = 0; i_sync_in = 1'b1;
    cycle();
    i_sync_in = 1'b0;
    repeat (5) begin cycle(); if (o_sync_fwd) strobes++; if (o_phase_en) pens++; end
    check("noload strobes", 16'(strobes), 16'd1);
    check("noload phase_en", 16'(pens), 16'd0);
    i_phase_load_en = 1'b1;

    // Timeout window.
    i_en = 1'b0; i_clear_flags = 1'b1;
    cycle();
    i_clear_flags = 1'b0; i_timeout = 16'd8; i_delay = 16'd0; i_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      check($sformatf("timeout after %0d", i), o_timeout, (i >= 8));
    end
    i_clear_flags = 1'b1;
    cycle();
    i_clear_flags = 1'b0;
    for (int i = 0; i < 40; i++) begin
      i_sync_in = (i % 5 == 0);
      cycle();
    end
    check("timeout with 5-cycle syncs", o_timeout, 1'b0);
    i_sync_in = 1'b0; i_timeout = 16'd0;
    repeat (30) cycle();
    check("timeout disabled", o_timeout, 1'b0);

    // External source adds two cycles of synchronizer latency.
    i_src_sel = 1'b1;
    repeat (3) cycle();
    i_sync_ext = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("ext fwd edge+%0d", i), o_sync_fwd, (i == 2));
    end
    i_sync_ext = 1'b0;
    repeat (3) cycle();
    i_src_sel = 1'b0;

    // Reset mid-delay cancels the strobe.
    i_delay = 16'd100; i_phase = 16'h5A5A; i_sync_in = 1'b1;
    cycle();
    i_sync_in = 1'b0;
    repeat (10) cycle();
    check("busy in long delay", o_busy, 1'b1);
    #1 i_reset = 1'b1;
    #2;
    check("midreset fwd",   o_sync_fwd, 1'b0);
    check("midreset busy",  o_busy,     1'b0);
    check("midreset phase", o_phase,    16'd0);
    check("midreset flags", {o_missed, o_timeout}, 2'b00);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    strobes = 0;
    repeat (120) begin cycle(); if (o_sync_fwd) strobes++; end
    check("strobe after reset", 16'(strobes), 16'd0);

    // Randomized traffic; delay and timeout change only while disabled.
    for (int seg = 0; seg < 6; seg++) begin
      i_en = 1'b0; i_sync_in = 1'b0;
      cycle();
      i_delay   = 16'($urandom_range(0, 6));
      i_timeout = 16'($urandom_range(0, 12));
      i_oneshot = 1'($urandom_range(0, 1));
      i_src_sel = 1'($urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        i_sync_in       = ($urandom_range(0, 3) == 0);
        i_sync_ext      = ($urandom_range(0, 2) == 0);
        i_arm           = ($urandom_range(0, 9) == 0);
        i_clear_flags   = ($urandom_range(0, 11) == 0);
        i_phase_load_en = 1'($urandom_range(0, 1));
        i_phase         = 16'($urandom);
        i_phase_dir     = 1'($urandom_range(0, 1));
        i_en            = ($urandom_range(0, 39) != 0);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/project_sync_phase_controller.md
# project_sync_phase_controller

Sync-input controller for the PWM peripheral: accepts a sync event from an upstream channel's sync output or from an external pin, delays it by a programmable number of cycles, and issues the one-cycle phase-load strobe plus captured phase value and direction consumed by a downstream slave period counter. It also supervises the sync stream, flagging syncs lost during a pending delay and syncs that fail to arrive within a timeout window.

## Interface
- No parameters; all widths fixed at 16 bits to match the period counters.
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  reset i_reset, asynchronous, active-high; clock i_clk.
- i_en  in  1  block enable; low forces FSM to IDLE.
- i_sync_in  in  1  internal sync (upstream counter's registered sync output).
- i_sync_ext  in  1  external sync pin, asynchronous to i_clk.
- i_src_sel  in  1  0 = i_sync_in, 1 = synchronized i_sync_ext.
- i_phase_load_en  in  1  gates o_phase_en.
- i_oneshot  in  1  1 = one-shot mode, 0 = continuous.
- i_arm  in  1  re-arm pulse for one-shot mode.
- i_delay  in  16  cycles between sync acceptance and strobe.
- i_phase  in  16  phase value to capture.
- i_phase_dir  in  1  direction to capture (0 = up, 1 = down).
- i_timeout  in  16  max cycles between accepted syncs; 0 disables.
- i_clear_flags  in  1  clears o_missed and o_timeout.
- o_sync_fwd  out  1  delayed sync pulse, one cycle.
- o_phase_en  out  1  o_sync_fwd AND i_phase_load_en.
- o_phase  out  16  phase captured at acceptance.
- o_phase_direction  out  1  direction captured at acceptance.
- o_busy  out  1  FSM not in IDLE.
- o_missed  out  1  sticky: sync edge arrived during DELAY.
- o_timeout  out  1  sticky: timeout window expired.

## Operation
- i_sync_ext passes through a 2-FF synchronizer (reset 0). Selected source goes through rising-edge detect (previous-value register, reset 0); only edges are events. Level held high = single event.
- Event accepted when i_en=1, FSM in IDLE or PULSE, and (continuous mode or armed).
- On acceptance: o_phase <= i_phase, o_phase_direction <= i_phase_dir; outputs hold until next acceptance. One-shot: armed cleared.
- FSM states: IDLE, DELAY, PULSE.
  - Accept with i_delay=0 -> PULSE; with i_delay>0 -> DELAY, cnt <= 1.
  - DELAY: cnt==i_delay -> PULSE, else cnt+1. i_delay sampled live; if changed below cnt, counter wraps at 16 bits (software must not change it while o_busy).
  - PULSE: o_sync_fwd=1 for exactly this cycle. Next edge -> IDLE, or straight back to DELAY/PULSE if a new event is accepted there.
- Event edge while in DELAY: ignored, o_missed <= 1. Event while disarmed in one-shot: ignored, no flag.
- i_arm sets armed; no effect if already armed. i_arm and acceptance on same edge: armed ends 1.
- Timeout counter: cleared on acceptance; increments each cycle with i_en=1 and i_timeout!=0; saturates at 0xFFFF; when it equals i_timeout, o_timeout <= 1.
- i_clear_flags clears both flags; a set condition on the same edge wins.
- i_en=0: FSM -> IDLE, cnt and timeout counter -> 0, o_sync_fwd/o_phase_en 0; flags, o_phase, armed and edge/synchronizer registers keep updating/holding normally.

## Timing
- Reset: all outputs 0, FSM IDLE, armed 0, all counters 0.
- Internal source edge sampled at clock edge k: o_sync_fwd high during cycle after edge k+D (D = i_delay). D=0 -> one cycle latency.
- External source: +2 cycles synchronizer latency.
- Back-to-back: event accepted during PULSE gives strobes D+1 cycles apart, no gap lost.
- Reset asserted mid-DELAY: strobe cancelled immediately, no pulse after release.
- o_phase valid from cycle after acceptance through and beyond the strobe.

## Test plan
- Continuous, internal, D=0, i_phase=0x1234, dir=1: one-cycle sync pulse at edge k -> o_phase_en high cycle after k, o_phase=0x1234, o_phase_direction=1.
- D=5, second sync 3 cycles after first -> single strobe 5 cycles after first, o_missed=1; i_clear_flags -> o_missed=0.
- One-shot, armed once, three syncs 20 cycles apart, D=0 -> exactly one strobe; pulse i_arm -> next sync strobes.
- i_sync_in held high 10 cycles, D=2 -> exactly one strobe; i_phase_load_en=0 -> o_sync_fwd pulses, o_phase_en stays 0.
- i_timeout=8, no syncs -> o_timeout set 8 cycles after enable; sync every 5 cycles -> never set; i_timeout=0 -> never set.
- External source, D=0: i_sync_ext rises -> strobe 3 cycles later; i_reset pulsed during D=100 delay -> no strobe, all outputs 0.
